// File: rtl/ft245_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : ft245_sync_tx
// Purpose  : FT245 synchronous-FIFO transmit path. Buffers fabric bytes and
//            bursts them to the FT chip under an external bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_sync_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 64
) (
  input  logic                        ft_clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        bus_req,
  input  logic                        bus_gnt,
  input  logic                        ft_txen,
  output logic                        ft_wrn,
  output logic [7:0]                  ft_data_out,
  output logic                        ft_data_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] C_MAX_BURST = BW'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_TURN    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            wrn_q, wrn_d;
  logic            oe_q, oe_d;
  logic            req_q, req_d;
  logic [7:0]      dout_q, dout_d;
  logic            w_push, w_pop;
  logic [7:0]      w_head;

  assign tx_ready = (count_q < C_DEPTH);
  assign w_push   = tx_valid && tx_ready;
  // Only WRITE drives ft_wrn low, so this is the host accepting the head byte.
  assign w_pop    = !wrn_q && !ft_txen && (count_q != '0);
  assign count_d  = count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign rd_ptr_d = rd_ptr_q + AW'(w_pop);

  // Head after this edge; forward the incoming byte when it lands in an
  // otherwise empty FIFO.
  assign w_head = ((count_q == (AW+1)'(w_pop)) && w_push) ? tx_data : mem_q[rd_ptr_d];

  always_ff @(posedge ft_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !ft_txen) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_TURN;
      end
      S_TURN: begin
        if (!ft_txen && (count_q != '0) && bus_gnt) state_d = S_WRITE;
        else                                         state_d = S_RELEASE;
      end
      S_WRITE: begin
        burst_d = burst_q + BW'(w_pop);
        if (ft_txen || (count_d == '0) || (burst_d == C_MAX_BURST) || !bus_gnt) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        burst_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        burst_d = '0;
      end
    endcase

    req_d  = (state_d == S_REQ) || (state_d == S_TURN) || (state_d == S_WRITE);
    oe_d   = (state_d == S_TURN) || (state_d == S_WRITE);
    wrn_d  = (state_d != S_WRITE);
    dout_d = oe_d ? w_head : dout_q;
  end

  always_ff @(posedge ft_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      burst_q  <= '0;
      wrn_q    <= 1'b1;
      oe_q     <= 1'b0;
      req_q    <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + AW'(w_push);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      wrn_q    <= wrn_d;
      oe_q     <= oe_d;
      req_q    <= req_d;
      dout_q   <= dout_d;
    end
  end

  assign fifo_count  = count_q;
  assign bus_req     = req_q;
  assign ft_wrn      = wrn_q;
  assign ft_data_oe  = oe_q;
  assign ft_data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_sync_tx
// Purpose  : Directed self-checking bench for ft245_sync_tx with a host log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_sync_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [4:0] fifo_count;
  logic       bus_req;
  logic       bus_gnt;
  logic       ft_txen;
  logic       ft_wrn;
  logic [7:0] ft_data_out;
  logic       ft_data_oe;
  logic       gnt_en;

  always #5 clk = ~clk;

  // Arbiter model: grants whenever enabled and requested.
  assign bus_gnt = gnt_en & bus_req;

  ft245_sync_tx #(.FIFO_DEPTH(16), .MAX_BURST(4)) dut (
    .ft_clk     (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_count (fifo_count),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .ft_txen    (ft_txen),
    .ft_wrn     (ft_wrn),
    .ft_data_out(ft_data_out),
    .ft_data_oe (ft_data_oe)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] host_log[$];
  int         pop_cyc[$];
  int         tenures[$];
  int         gaps[$];
  int         cur_ten = 0;
  int         low_run = 0;
  logic       prev_oe = 1'b0;
  logic       had_req = 1'b0;

  // Host side: accepts a byte on every edge with WR# and TXE# both low.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (prev_oe && !ft_data_oe) begin
      tenures.push_back(cur_ten);
      cur_ten = 0;
    end
    prev_oe = ft_data_oe;
    if (!rst && !ft_wrn && !ft_txen) begin
      host_log.push_back(ft_data_out);
      pop_cyc.push_back(cyc);
      cur_ten = cur_ten + 1;
    end
    if (!bus_req) begin
      low_run = low_run + 1;
    end else begin
      if (had_req && low_run > 0) gaps.push_back(low_run);
      low_run = 0;
      had_req = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int k;
    k = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_log(input string tag, input int n, input int maxc);
    int k;
    k = 0;
    while (host_log.size() < n && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, host_log.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, tbase, gbase, bad, gmin;

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; ft_txen = 1'b1; gnt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wrn",   ft_wrn,      1);
    chk("rst_oe",    ft_data_oe,  0);
    chk("rst_dout",  ft_data_out, 8'h00);
    chk("rst_req",   bus_req,     0);
    chk("rst_count", fifo_count,  0);
    chk("rst_ready", tx_ready,    1);
    rst = 1'b0;
    @(negedge clk);

    // Async reset between edges clears a buffered byte; pushes ignored in reset.
    push_byte(8'hC3);
    tx_valid = 1'b0;
    chk("pre_rst_count", fifo_count, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_count", fifo_count, 0);
    tx_data = 8'hEE; tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold_count", fifo_count, 0);
    chk("rst_hold_ready", tx_ready, 1);
    tx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Basic burst A1,A2,A3.
    ft_txen = 1'b0; gnt_en = 1'b1;
    base = host_log.size();
    push_byte(8'hA1);
    e0 = cyc - 1;
    push_byte(8'hA2);
    push_byte(8'hA3);
    tx_valid = 1'b0;
    wait_log("basic_len", base + 3, 50);
    repeat (4) @(negedge clk);
    chk("basic_b0", host_log[base],     8'hA1);
    chk("basic_b1", host_log[base + 1], 8'hA2);
    chk("basic_b2", host_log[base + 2], 8'hA3);
    chk("basic_latency", pop_cyc[base] - e0, 4);
    chk("basic_rate", pop_cyc[base + 2] - pop_cyc[base], 2);
    chk("basic_tenure", tenures[tenures.size() - 1], 3);
    chk("basic_count", fifo_count, 0);
    chk("basic_wrn", ft_wrn, 1);
    chk("basic_oe", ft_data_oe, 0);
    chk("basic_req", bus_req, 0);

    // TXE# stall after the first byte.
    base = host_log.size();
    push_byte(8'hB1);
    push_byte(8'hB2);
    push_byte(8'hB3);
    tx_valid = 1'b0;
    wait_log("stall_first", base + 1, 50);
    ft_txen = 1'b1;
    repeat (5) @(negedge clk);
    chk("stall_len", host_log.size(), base + 1);
    chk("stall_count", fifo_count, 2);
    chk("stall_req", bus_req, 0);
    chk("stall_wrn", ft_wrn, 1);
    ft_txen = 1'b0;
    wait_log("stall_resume", base + 3, 50);
    repeat (4) @(negedge clk);
    chk("stall_b0", host_log[base],     8'hB1);
    chk("stall_b1", host_log[base + 1], 8'hB2);
    chk("stall_b2", host_log[base + 2], 8'hB3);
    chk("stall_ten1", tenures[tenures.size() - 2], 1);
    chk("stall_ten2", tenures[tenures.size() - 1], 2);
    chk("stall_count_end", fifo_count, 0);

    // Full FIFO with bus withheld; 17th byte waits upstream.
    gnt_en = 1'b0;
    base = host_log.size();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    tx_data = 8'h5A; tx_valid = 1'b1;
    chk("full_count", fifo_count, 16);
    chk("full_ready", tx_ready, 0);
    repeat (2) @(negedge clk);
    chk("full_hold", fifo_count, 16);
    gnt_en = 1'b1;
    @(negedge clk);
    chk("full_ready_pre_pop", tx_ready, 0);
    wait_log("full_first_pop", base + 1, 20);
    chk("full_ready_post_pop", tx_ready, 1);
    chk("full_count_post_pop", fifo_count, 15);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_log("full_len", base + 17, 300);
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 16; i++) if (host_log[base + i] !== 8'(8'h10 + i)) bad++;
    chk("full_order", bad, 0);
    chk("full_last", host_log[base + 16], 8'h5A);
    chk("full_count_end", fifo_count, 0);

    // Burst limit: 10 bytes in tenures of 4,4,2.
    gnt_en = 1'b0;
    base  = host_log.size();
    tbase = tenures.size();
    for (int i = 0; i < 10; i++) push_byte(8'(8'h30 + i));
    tx_valid = 1'b0;
    @(negedge clk);
    gbase = gaps.size();
    gnt_en = 1'b1;
    wait_log("burst_len", base + 10, 200);
    repeat (6) @(negedge clk);
    chk("burst_ntenures", tenures.size() - tbase, 3);
    chk("burst_ten0", tenures[tbase],     4);
    chk("burst_ten1", tenures[tbase + 1], 4);
    chk("burst_ten2", tenures[tbase + 2], 2);
    bad = 0;
    for (int i = 0; i < 10; i++) if (host_log[base + i] !== 8'(8'h30 + i)) bad++;
    chk("burst_order", bad, 0);
    gmin = 1000;
    for (int i = gbase; i < gaps.size(); i++) if (gaps[i] < gmin) gmin = gaps[i];
    chk("burst_ngaps", gaps.size() - gbase, 2);
    chk("burst_gap_ge2", (gmin >= 2), 1);

    // Reset mid-burst after two of five bytes.
    base = host_log.size();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
    tx_valid = 1'b0;
    wait_log("mid_two", base + 2, 50);
    #2 rst = 1'b1;
    #1;
    chk("mid_wrn", ft_wrn, 1);
    chk("mid_oe", ft_data_oe, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_req", bus_req, 0);
    chk("mid_dout", ft_data_out, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_more", host_log.size() - base, 2);
    chk("mid_b0", host_log[base],     8'h40);
    chk("mid_b1", host_log[base + 1], 8'h41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ft245_sync_tx.md
# ft245_sync_tx

Transmit half of the FT245 synchronous-FIFO link to the host, clocked by the FT chip's 60 MHz `ft_clk`. It accepts bytes from the FPGA fabric (status, phase readback) over a valid/ready stream and buffers them in an internal FIFO. It then bursts them to the FT chip with `ft_wrn`, yielding the shared `ft_data` bus through an external arbiter that also serves the receive path. It sits beside the receive block inside `top`; `top` owns the `ft_data` tristate using `ft_data_out`/`ft_data_oe`.

## Interface
- `FIFO_DEPTH`, 16: internal byte FIFO depth; power of two, ≥2.
- `MAX_BURST`, 64: maximum bytes written per bus tenure before mandatory release; ≥1.

- `ft_clk` in 1: sole clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a byte; equals `count < FIFO_DEPTH`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: bytes currently buffered.
- `bus_req` out 1: request for the `ft_data` bus.
- `bus_gnt` in 1: arbiter grant. The arbiter holds it while `bus_req` is high.
- `ft_txen` in 1: FT TXE#, active-low, meaning "room in FT TX FIFO".
- `ft_wrn` out 1: FT WR#, active-low.
- `ft_data_out` out 8: byte presented to `ft_data`.
- `ft_data_oe` out 1: drive enable for `ft_data`.

## Operation
- **Push rule:** a push occurs on an edge with `tx_valid && tx_ready`. The FIFO takes the byte and `count` increments, or stays unchanged on a simultaneous pop.
- **Full FIFO:** `tx_ready` depends only on `count`, so a full FIFO rejects a push even when the same edge pops.
- **Pop rule:** a pop (host acceptance) occurs on an edge where registered `ft_wrn`=0 and `ft_txen`=0.
- **State machine:** IDLE, REQ, TURN, WRITE, RELEASE.
  - IDLE: `bus_req`=0, `ft_data_oe`=0, `ft_wrn`=1. Moves to REQ when `count>0 && !ft_txen`.
  - REQ: `bus_req`=1. Moves to TURN when `bus_gnt`=1; waits indefinitely otherwise.
  - TURN: `ft_data_oe`=1, `ft_data_out`=FIFO head, `ft_wrn`=1. This is a one-cycle data setup. Moves to WRITE if `!ft_txen && count>0 && bus_gnt`, otherwise to RELEASE.
  - WRITE: `ft_wrn`=0 and `ft_data_out`=FIFO head. On each pop, the burst counter increments and `ft_data_out` advances to the next head on the same edge.
    - Exits to RELEASE on the first edge where any of these holds: `ft_txen`=1, or the FIFO is empty after the pop, or the burst counter reaches `MAX_BURST`, or `bus_gnt`=0.
    - If the exit edge also satisfies the pop rule, that byte counts as sent.
  - RELEASE: `ft_wrn`=1, `ft_data_oe`=0, `bus_req`=0, burst counter cleared. Moves unconditionally to IDLE, so `bus_req` is low for at least 2 cycles between tenures.
- **`ft_txen` rising mid-burst:** when `ft_txen` goes high on an edge with `ft_wrn`=0, no pop occurs. The byte stays at the FIFO head and is resent in the next tenure. Every byte reaches the host exactly once.
- **Unexpected grant loss:** a `bus_gnt` drop outside RELEASE/IDLE violates the arbiter contract. The block still exits cleanly to RELEASE and loses no data.
- **Reset:** asserting `rst` (asynchronous, including mid-burst) forces IDLE, clears the FIFO and burst counter, and drives outputs to reset values. Pushes while `rst` is high are ignored.

## Timing
- **Reset values:**
  - `ft_wrn`=1, `ft_data_oe`=0, `ft_data_out`=8'h00, `bus_req`=0
  - `fifo_count`=0, `tx_ready`=1
- **Latency with grant already high and `ft_txen`=0** (push on edge E0):
  - E1: IDLE→REQ.
  - E2: REQ→TURN.
  - E3: TURN→WRITE, `ft_wrn` goes low.
  - E4: first byte accepted.
- **Throughput:** sustained one byte per `ft_clk` inside WRITE.
- All outputs are registered. `tx_ready` is a combinational decode of the registered count.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. `count` is one bit wider to distinguish full from empty.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → all outputs at the reset values immediately. With `rst` held, `tx_valid`=1 changes nothing.
- **Basic burst:** push A1,A2,A3 back-to-back with `bus_gnt` tied to `bus_req` and `ft_txen`=0.
  - → `ft_wrn` low for exactly 3 cycles with data A1,A2,A3.
  - → then RELEASE and IDLE, `fifo_count`=0.
- **`ft_txen` stall:** same 3 bytes, raise `ft_txen` on the edge presenting A2.
  - → A2 not popped, block releases; lower `ft_txen` → new tenure sends A2,A3.
  - → host log is exactly A1,A2,A3.
- **Full FIFO:** push 16 bytes with `bus_gnt`=0.
  - → `tx_ready`=0, `fifo_count`=16; 17th byte (5A) held upstream.
  - → grant the bus → `tx_ready` returns 1 one edge after the first pop; 5A is sent last.
- **Burst limit:** `MAX_BURST`=4, 10 bytes queued.
  - → three tenures of 4, 4, 2 bytes in order.
  - → `bus_req` low ≥2 cycles between tenures.
- **Reset mid-burst:** assert `rst` after 2 of 5 bytes.
  - → `ft_wrn`=1 and `ft_data_oe`=0 without waiting for an edge; `fifo_count`=0.
  - → after release, no further writes occur.
